// File: rtl/instruction_cache_pkg.sv
// ============================================================================
//  Module  : instruction_cache_pkg
//  Brief   : Shared encodings for the instruction cache and its main-memory
//            interface (memory commands, memory status, refill FSM states).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_cache_pkg;

  // Commands driven towards main memory
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  // Registered completion status returned by main memory
  localparam logic [1:0] MEM_RESTING       = 2'd0;
  localparam logic [1:0] MEM_INST_FINISHED = 2'd1;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd2;

  // Cache controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
//  Module  : icache_refill_ctrl
//  Brief   : Line refill sequencer. Issues one word read per REQ cycle,
//            checks the registered memory status in WAIT, strobes a word
//            write on success and keeps the word counter for retries.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl
  import instruction_cache_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 17,
  parameter  int WORD_BITS      = 2,
  localparam int LINE_ADDR_BITS = ADDR_WIDTH - 2 - WORD_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_req,
  input  logic                      in_wait,
  input  logic [LINE_ADDR_BITS-1:0] line_addr,
  input  logic [1:0]                mem_status,
  output logic [1:0]                mem_signal,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      word_we,
  output logic [WORD_BITS-1:0]      word_idx,
  output logic                      last_word
);

  logic [WORD_BITS-1:0] counter_q;
  logic [WORD_BITS-1:0] counter_d;

  // A read is only accepted if memory reports the instruction port finished;
  // anything else means the data cache won and the same word is retried.
  assign word_we   = in_wait && (mem_status == MEM_INST_FINISHED);
  assign last_word = (counter_q == {WORD_BITS{1'b1}});
  assign word_idx  = counter_q;

  // Memory sees a READ only in the single REQ cycle, so READ never repeats back-to-back
  assign mem_signal = in_req ? MEM_READ : MEM_NOP;
  assign mem_addr   = in_req ? {line_addr, counter_q, 2'b00} : '0;

  // Word counter: cleared on a new miss, advanced on each stored word
  always_comb begin
    counter_d = counter_q;
    if (start) begin
      counter_d = '0;
    end else if (word_we) begin
      counter_d = counter_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
//  Module  : instruction_cache
//  Brief   : Direct-mapped read-only instruction cache. Hits answer one cycle
//            after the request; misses refill a whole line word by word from
//            main memory, retrying words pre-empted by data-cache traffic.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_fetch_enabled,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  inst_valid,
  output logic [LEN-1:0]        inst,
  output logic [1:0]            i_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0] i_cache_mem_vis_addr,
  input  logic [LEN-1:0]        mem_data,
  input  logic [1:0]            mem_status
);

  localparam int OFF_BITS       = 2;
  localparam int WORD_BITS      = $clog2(LINE_WORDS);
  localparam int LINES          = 1 << INDEX_BITS;
  localparam int TAG_BITS       = ADDR_WIDTH - OFF_BITS - WORD_BITS - INDEX_BITS;
  localparam int LINE_ADDR_BITS = ADDR_WIDTH - OFF_BITS - WORD_BITS;
  localparam int NBYTES         = LEN / BYTE_SIZE;

  // Storage arrays
  logic [LEN-1:0]      data_arr [LINES*LINE_WORDS];
  logic [TAG_BITS-1:0] tag_arr  [LINES];

  // Registered state
  logic [1:0]                state_q, state_d;
  logic [LINE_ADDR_BITS-1:0] line_q, line_d;
  logic [WORD_BITS-1:0]      word_q, word_d;
  logic                      flush_pend_q, flush_pend_d;
  logic                      inst_valid_q, inst_valid_d;
  logic [LEN-1:0]            inst_q, inst_d;
  logic [LINES-1:0]          valid_q, valid_d;

  // Address decode of the incoming fetch
  logic [WORD_BITS-1:0]  pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  unused_pc_bits;

  assign pc_word        = pc[OFF_BITS +: WORD_BITS];
  assign pc_index       = pc[OFF_BITS+WORD_BITS +: INDEX_BITS];
  assign pc_tag         = pc[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_pc_bits = ^pc[OFF_BITS-1:0];

  // Refill line split
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;

  assign fill_index = line_q[INDEX_BITS-1:0];
  assign fill_tag   = line_q[LINE_ADDR_BITS-1 -: TAG_BITS];

  // The cycle carrying an inst_valid pulse is not served, giving the fetch
  // stage one cycle to move pc; a flush in the same cycle forces a miss.
  logic serve_req, hit, miss_start;

  assign serve_req  = inst_fetch_enabled && !inst_valid_q;
  assign hit        = valid_q[pc_index] && (tag_arr[pc_index] == pc_tag) && !flush;
  assign miss_start = (state_q == S_IDLE) && serve_req && !hit;

  // Memory words arrive with the addressed byte in the MSBs; reverse to little-endian
  logic [LEN-1:0] mem_swapped;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bswap
      assign mem_swapped[gi*BYTE_SIZE +: BYTE_SIZE] = mem_data[(NBYTES-1-gi)*BYTE_SIZE +: BYTE_SIZE];
    end
  endgenerate

  logic                 word_we, last_word;
  logic [WORD_BITS-1:0] fill_word;

  icache_refill_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_BITS  (WORD_BITS)
  ) u_refill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (miss_start),
    .in_req     (state_q == S_REQ),
    .in_wait    (state_q == S_WAIT),
    .line_addr  (line_q),
    .mem_status (mem_status),
    .mem_signal (i_cache_mem_vis_signal),
    .mem_addr   (i_cache_mem_vis_addr),
    .word_we    (word_we),
    .word_idx   (fill_word),
    .last_word  (last_word)
  );

  // Controller next state: lookup in IDLE, sequence refill, deliver in DONE
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    word_d       = word_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    if (flush) begin
      valid_d = '0;
    end
    case (state_q)
      S_IDLE: begin
        if (serve_req) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = data_arr[{pc_index, pc_word}];
          end else begin
            state_d      = S_REQ;
            line_d       = pc[ADDR_WIDTH-1 -: LINE_ADDR_BITS];
            word_d       = pc_word;
            flush_pend_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (flush) flush_pend_d = 1'b1;
      end
      S_WAIT: begin
        if (flush) flush_pend_d = 1'b1;
        if (word_we && last_word) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        inst_valid_d = 1'b1;
        inst_d       = data_arr[{fill_index, word_q}];
        // A flush seen during the refill leaves the new line invalid
        if (!flush_pend_q && !flush) begin
          valid_d[fill_index] = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers, aborted asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      word_q       <= '0;
      flush_pend_q <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      word_q       <= word_d;
      flush_pend_q <= flush_pend_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
    end
  end

  // Data and tag arrays; validity is tracked separately so no reset is needed here
  always_ff @(posedge clk) begin
    if (word_we) begin
      data_arr[{fill_index, fill_word}] <= mem_swapped;
    end
    if (state_q == S_DONE) begin
      tag_arr[fill_index] <= fill_tag;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;

endmodule

`default_nettype wire
